if_id_fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined CPU; sits directly upstream of the ID stage and feeds its instruction and PC+4.
Holds the PC and a loadable instruction memory.
Honours stall from the hazard unit and branch redirect/flush from EXE.
Provides fetch/stall performance counters for the bench.

---
 rtl/if_id_fetch_stage.sv | 96 +++++++++
 tb/tb_if_id_fetch_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with loadable instruction memory and IF/ID pipeline register.
// Priority per edge: rst > branch_taken (redirect + flush) > stall (hold) > sequential fetch.
module if_id_fetch_stage #(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic              imem_we,
   input  logic [ADDR_W-1:0] imem_waddr,
   input  logic [31:0]       imem_wdata,
   output logic [31:0]       PCOUT,
   output logic [31:0]       INST,
   output logic [31:0]       inst_if_id,
   output logic [31:0]       pc_plus4_if_id,
   output logic              valid_if_id,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] mem_q [0:DEPTH-1];

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] pc_plus4;

   // Memory is deliberately left out of reset so a loaded program survives rst.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         mem_q[imem_waddr] <= imem_wdata;
      end
   end

   assign INST     = mem_q[pc_q[ADDR_W+1:2]];
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d        = pc_q;
      inst_d      = inst_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (branch_taken) begin
         // Redirect wins over a concurrent stall; the flushed slot is not counted as a stall.
         pc_d    = branch_target & ~32'd3;
         inst_d  = NOP_INST;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         pc_d        = pc_plus4;
         inst_d      = INST;
         pc4_d       = pc_plus4;
         valid_d     = 1'b1;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inst_q      <= NOP_INST;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign PCOUT          = pc_q;
   assign inst_if_id     = inst_q;
   assign pc_plus4_if_id = pc4_q;
   assign valid_if_id    = valid_q;
   assign fetch_count    = fetch_cnt_q;
   assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: reset, fetch, stall, branch collision, wrap, load-while-fetch.
module tb_if_id_fetch_stage;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              branch_taken;
   logic [31:0]       branch_target;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic [31:0]       PCOUT, INST, inst_if_id, pc_plus4_if_id, fetch_count, stall_count;
   logic              valid_if_id;

   int n_checks = 0;
   int n_errors = 0;

   if_id_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .PCOUT(PCOUT), .INST(INST), .inst_if_id(inst_if_id),
      .pc_plus4_if_id(pc_plus4_if_id), .valid_if_id(valid_if_id),
      .fetch_count(fetch_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      tick();
      imem_we = 1'b0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic valid);
      check({tag, "_pc"}, PCOUT, pc);
      check({tag, "_inst"}, inst_if_id, inst);
      check({tag, "_pc4"}, pc_plus4_if_id, pc4);
      check({tag, "_valid"}, {31'd0, valid_if_id}, {31'd0, valid});
   endtask

   logic [31:0] prog [0:7];

   initial begin
      prog[0] = 32'h11111111; prog[1] = 32'h22222222; prog[2] = 32'h33333333; prog[3] = 32'h44444444;
      prog[4] = 32'h55555555; prog[5] = 32'h66666666; prog[6] = 32'h77777777; prog[7] = 32'h88888888;
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = 32'h0;

      // Load program while held in reset.
      for (int i = 0; i < 8; i++) load(ADDR_W'(i), prog[i]);
      load(8'd255, 32'hA5A5A5A5);

      check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      check("reset_fetch_cnt", fetch_count, 32'd0);
      check("reset_stall_cnt", stall_count, 32'd0);
      check("reset_INST", INST, 32'h11111111);

      // Sequential fetch.
      rst = 1'b0;
      tick();
      check_ifid("fetch1", 32'h4, 32'h11111111, 32'h4, 1'b1);
      tick();
      check_ifid("fetch2", 32'h8, 32'h22222222, 32'h8, 1'b1);

      // Stall three cycles: everything holds.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check_ifid("stall", 32'h8, 32'h22222222, 32'h8, 1'b1);
      check("stall_cnt3", stall_count, 32'd3);
      check("stall_fetch_cnt", fetch_count, 32'd2);
      stall = 1'b0;
      tick();
      check_ifid("release", 32'hC, 32'h33333333, 32'hC, 1'b1);
      tick();
      check_ifid("fetch4", 32'h10, 32'h44444444, 32'h10, 1'b1);
      check("fetch_cnt4", fetch_count, 32'd4);

      // Write mem[4] on the edge that fetches it: old word is latched.
      imem_we = 1'b1; imem_waddr = 8'd4; imem_wdata = 32'hDEADBEEF;
      tick();
      imem_we = 1'b0;
      check_ifid("lwf", 32'h14, 32'h55555555, 32'h14, 1'b1);
      check("lwf_INST", INST, 32'h66666666);

      // Branch with simultaneous stall: branch wins, stall not counted.
      branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h6;
      tick();
      branch_taken = 1'b0; stall = 1'b0;
      check_ifid("brst", 32'h4, 32'h0, 32'h0, 1'b0);
      check("brst_stall_cnt", stall_count, 32'd3);
      check("brst_fetch_cnt", fetch_count, 32'd5);
      tick();
      check_ifid("brst_next", 32'h8, 32'h22222222, 32'h8, 1'b1);
      check("brst_next_fetch_cnt", fetch_count, 32'd6);

      // Re-branch to 0x10 now fetches the new word.
      branch_taken = 1'b1; branch_target = 32'h10;
      tick();
      branch_taken = 1'b0;
      check("rebr_INST", INST, 32'hDEADBEEF);
      tick();
      check_ifid("rebr_fetch", 32'h14, 32'hDEADBEEF, 32'h14, 1'b1);

      // Index wrap and 32-bit PC wrap.
      branch_taken = 1'b1; branch_target = 32'h400;
      tick();
      check("wrap_pc400", PCOUT, 32'h400);
      check("wrap_INST400", INST, 32'h11111111);
      branch_target = 32'hFFFFFFFC;
      tick();
      branch_taken = 1'b0;
      check("wrap_pcmax", PCOUT, 32'hFFFFFFFC);
      check("wrap_INSTmax", INST, 32'hA5A5A5A5);
      tick();
      check_ifid("wrap_edge", 32'h0, 32'hA5A5A5A5, 32'h0, 1'b1);
      check("wrap_fetch_cnt", fetch_count, 32'd8);

      // Reset during a stall (and a branch) with a valid instruction held.
      stall = 1'b1;
      tick();
      check("pre_rst_stall_cnt", stall_count, 32'd4);
      check("pre_rst_valid", {31'd0, valid_if_id}, 32'd1);
      rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      tick();
      rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
      check_ifid("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
      check("midrst_fetch_cnt", fetch_count, 32'd0);
      check("midrst_stall_cnt", stall_count, 32'd0);
      check("midrst_INST", INST, 32'h11111111);
      tick();
      check_ifid("post_rst", 32'h4, 32'h11111111, 32'h4, 1'b1);
      branch_taken = 1'b1; branch_target = 32'h13;
      tick();
      branch_taken = 1'b0;
      check("post_rst_pc_align", PCOUT, 32'h10);
      check("post_rst_mem", INST, 32'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
